// File: rtl/text_renderer.sv
// Text-mode pixel generator: cell counters -> VRAM -> font ROM -> serialiser with blinking block cursor.
// Fixed 3-cycle latency on every output; free-running pixel pipe with no stalls or backpressure.
module text_renderer #(
  parameter int          COLS = 80,
  parameter int          ROWS = 60,
  parameter int          AW   = 13,
  parameter logic [23:0] FG   = 24'hFFFFFF,
  parameter logic [23:0] BG   = 24'h000000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [AW-1:0] vram_ad,
  input  logic [7:0]    vram_dout,
  output logic [10:0]   font_ad,
  input  logic [7:0]    font_dout,
  input  logic [6:0]    cur_col,
  input  logic [5:0]    cur_row,
  input  logic          cur_en,
  output logic          de_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic [23:0]   rgb
);

  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS);
  localparam logic [AW-1:0] ROW_STEP = AW'(COLS);

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       live;
    logic       blank;
    logic       curs;
    logic [2:0] subx;
  } pipe_t;

  logic [2:0]    subx;
  logic [2:0]    suby;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] row_base;
  logic [4:0]    frame_cnt;
  logic          synced;
  logic          de_prev;
  logic          vs_prev;
  logic          vs_rise;
  logic          de_fall;
  logic          cur_hit;
  logic          pix;
  logic [2:0]    suby_d1;
  pipe_t         p0;
  pipe_t         p1;
  pipe_t         p2;

  assign vs_rise = vs_in & ~vs_prev;
  assign de_fall = ~de_in & de_prev;
  assign vram_ad = row_base + AW'(col);
  assign font_ad = {vram_dout, suby_d1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      subx      <= '0;
      suby      <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      frame_cnt <= '0;
      synced    <= 1'b0;
      de_prev   <= 1'b0;
      vs_prev   <= 1'b0;
    end else begin
      de_prev <= de_in;
      vs_prev <= vs_in;
      // Frame clear outranks both the pixel step and the line step.
      if (vs_rise) begin
        subx      <= '0;
        suby      <= '0;
        col       <= '0;
        row       <= '0;
        row_base  <= '0;
        frame_cnt <= frame_cnt + 5'd1;
        synced    <= 1'b1;
      end else if (synced) begin
        if (de_in) begin
          subx <= subx + 3'd1;
          if (subx == 3'd7 && col < COL_MAX)
            col <= col + 1'b1;
        end else if (de_fall) begin
          subx <= '0;
          col  <= '0;
          suby <= suby + 3'd1;
          if (suby == 3'd7 && row < ROW_MAX) begin
            row      <= row + 1'b1;
            row_base <= row_base + ROW_STEP;
          end
        end
      end
    end
  end

  assign cur_hit = cur_en & frame_cnt[4] &
                   (32'(col) == 32'(cur_col)) & (32'(row) == 32'(cur_row));

  always_comb begin
    p0       = '0;
    p0.de    = de_in;
    p0.hs    = hs_in;
    p0.vs    = vs_in;
    p0.live  = de_in & synced;
    p0.blank = (col >= COL_MAX) || (row >= ROW_MAX);
    p0.curs  = cur_hit;
    p0.subx  = subx;
  end

  // 7 - subx on a 3-bit index is its bitwise complement: MSB is the leftmost pixel.
  assign pix = font_dout[~p2.subx] ^ p2.curs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1      <= '0;
      p2      <= '0;
      suby_d1 <= '0;
      de_out  <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      rgb     <= '0;
    end else begin
      p1      <= p0;
      p2      <= p1;
      suby_d1 <= suby;
      de_out  <= p2.de;
      hs_out  <= p2.hs;
      vs_out  <= p2.vs;
      if (!p2.live)
        rgb <= '0;
      else if (p2.blank)
        rgb <= BG;
      else
        rgb <= pix ? FG : BG;
    end
  end

endmodule

// File: doc/text_renderer.md
# text_renderer

Text-mode pixel generator for the video path: the read side of the 8x8 font ROM (`font8x8`). It tracks the character cell from the timing generator's DE/HS/VS and reads the character code from text VRAM. It then reads the glyph row from `font8x8`, serialises it MSB-first into pixels, and overlays a blinking block cursor. It sits between the video timing generator and the HDMI/RGB output stage.

## Interface
Parameters:
- `COLS`, 80: character columns per row.
- `ROWS`, 60: character rows per frame.
- `AW`, 13: VRAM address width (must hold COLS*ROWS-1).
- `FG`, 24'hFFFFFF: foreground RGB.
- `BG`, 24'h000000: background RGB.

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `de_in` in 1: active-video enable from the timing generator.
- `hs_in` in 1: hsync, passed through.
- `vs_in` in 1: vsync, active-high; its rising edge marks frame start.
- `vram_ad` out AW: text VRAM address (combinational from the cell counters).
- `vram_dout` in 8: character code; synchronous RAM, valid 1 cycle after `vram_ad`.
- `font_ad` out 11: {code[7:0], glyph row[2:0]}; drives `font8x8.ad` (ce=oce=1, reset=0).
- `font_dout` in 8: glyph row, valid 1 cycle after `font_ad`. Bit 7 is the leftmost pixel.
- `cur_col` in 7: cursor column.
- `cur_row` in 6: cursor row.
- `cur_en` in 1: cursor enable.
- `de_out` out 1: `de_in` delayed by 3 cycles.
- `hs_out` out 1: `hs_in` delayed by 3 cycles.
- `vs_out` out 1: `vs_in` delayed by 3 cycles.
- `rgb` out 24: pixel colour, registered.

## Operation
- Counters:
  - `subx` (0-7) and `col` (0..COLS) track position within the line.
  - `suby` (0-7) and `row` (0..ROWS) track position within the frame.
  - `row_base` (AW bits) is the VRAM address of the first cell in the current row.
  - `frame_cnt` is 5 bits.
  - `synced` is 1 bit.
- `vs_in` rising edge:
  - Clears `subx`, `col`, `suby`, `row` and `row_base`.
  - Increments `frame_cnt` (wraps 31→0).
  - Sets `synced`=1.
- Each cycle with `de_in`=1: `subx`++. On the 7→0 wrap, `col`++, saturating at COLS.
- `de_in` falling edge:
  - `subx`=0, `col`=0, `suby`++.
  - On the 7→0 wrap: `row`++ (saturating at ROWS) and `row_base` += COLS (only while `row` < ROWS).
- Address and glyph path:
  - `vram_ad` = `row_base` + `col`.
  - `font_ad` = {`vram_dout`, `suby` delayed 1 cycle}.
- Pixel bit = `font_dout`[7 − `subx` delayed 2 cycles].
- Blanking: the cell is blank (BG) when its `col` ≥ COLS or `row` ≥ ROWS, evaluated at fetch and carried down the pipe.
- Cursor:
  - Applies when `cur_en`=1, `frame_cnt[4]`=1, and the cell's (`col`, `row`) equals (`cur_col`, `cur_row`).
  - The pixel bit is inverted for all 64 pixels of that cell.
  - Cursor position inputs are sampled at fetch (cycle t).
- `rgb` = pixel ? FG : BG when delayed DE=1. Otherwise 0.
- Until `synced`=1 after reset, `rgb`=0 and counters do not advance. Sync outputs still follow the delayed inputs.

## Timing
- Pipeline: cycle t, `de_in`=1, `vram_ad` valid → t+1 `vram_dout` and `font_ad` valid → t+2 `font_dout` valid → t+3 `rgb`/`de_out`/`hs_out`/`vs_out` registered.
- Fixed latency is 3 cycles for all outputs. No stalls or backpressure.
- Reset values: `rgb`=0; `de_out`=`hs_out`=`vs_out`=0; all counters 0; `frame_cnt`=0; `synced`=0. Delay pipes are cleared.
- Reset asserted mid-frame: outputs go to 0 immediately (async). After release, output stays blank until the next `vs_in` rising edge.
- `vs_in` rising while `de_in`=1 is illegal input; the clear takes precedence over the increment.
- A `de_in` falling edge and a `vs_in` rising edge in the same cycle: the frame clear wins.
- `row_base` addition is AW bits with no wrap. This is legal because it is gated at `row` < ROWS.

## Test plan
- Glyph: VRAM cell 0 = 8'h41 ('A'), font model row 0 = 8'h30. On the first line after vs, pixels 0-7 → BG, BG, FG, FG, BG, BG, BG, BG. `de_out` goes high exactly 3 cycles after `de_in`.
- Addressing: 640x480 frame, line 8, pixel 16 → `vram_ad`=82. `font_ad` = {code at 82, 3'd0}. Line 479, pixel 639 → `vram_ad`=4799.
- Overrun: 800-pixel DE with COLS=80 → pixels 640-799 are BG and `col` saturates at 80. Line 480+ with ROWS=60 → all BG.
- Cursor: `cur_en`=1, (`cur_col`,`cur_row`)=(2,1), space glyph (all 0). Frames 16-31 show an FG 8x8 block at x 16-23, y 8-15. Frames 0-15 show BG there.
- Reset: assert `reset_n`=0 mid-line → `rgb`, `de_out`, `hs_out`, `vs_out` = 0 in the same cycle. After release, `rgb`=0 until the next vs rising edge, and the following frame renders correctly.
- Edge coincidence: `de_in` falling edge and `vs_in` rising edge in the same cycle → `suby`=0, `row`=0, `row_base`=0; the next line fetches from address 0.
